// File: rtl/mesh_term_src.sv
`default_nettype none
// ============================================================================
// mesh_term_src : mesh terminal source queue. Validates destinations, builds
// packets and presents them first-word-fall-through to the router.  Rev 1.0
// ============================================================================
module mesh_term_src #(
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int SRC_ROW    = 0,
  parameter int SRC_COL    = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_vld,
  output logic                               wr_rdy,
  input  logic [3:0]                         wr_row,
  input  logic [3:0]                         wr_colum,
  input  logic                               wr_mode,
  input  logic [pckg_sz-18:0]                wr_payload,
  output logic                               pndng_i_in,
  output logic [pckg_sz-1:0]                 data_out_i_in,
  input  logic                               popin,
  output logic [$clog2(fifo_depth+1)-1:0]    count,
  output logic                               bad_dst,
  output logic [15:0]                        drop_cnt
);

  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CNT_W = $clog2(fifo_depth+1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(fifo_depth-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(fifo_depth);
  localparam logic [3:0] ROW_LAST = 4'(ROWS+1);
  localparam logic [3:0] COL_LAST = 4'(COLUMS+1);
  localparam logic [3:0] ROW_MAX  = 4'(ROWS);
  localparam logic [3:0] COL_MAX  = 4'(COLUMS);
  localparam logic [3:0] SELF_ROW = 4'(SRC_ROW);
  localparam logic [3:0] SELF_COL = 4'(SRC_COL);

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               on_ns_edge;
  logic               on_ew_edge;
  logic               is_self;
  logic               dst_ok;
  logic               accept;
  logic               push;
  logic               pop;
  logic [pckg_sz-1:0] packet;

  // Only boundary terminals other than ourselves are legal destinations.
  always_comb begin
    on_ns_edge = (wr_row == 4'd0 || wr_row == ROW_LAST) &&
                 (wr_colum >= 4'd1) && (wr_colum <= COL_MAX);
    on_ew_edge = (wr_colum == 4'd0 || wr_colum == COL_LAST) &&
                 (wr_row >= 4'd1) && (wr_row <= ROW_MAX);
    is_self    = (wr_row == SELF_ROW) && (wr_colum == SELF_COL);
    dst_ok     = (on_ns_edge || on_ew_edge) && !is_self;
  end

  assign packet        = {8'h00, wr_row, wr_colum, wr_mode, wr_payload};
  assign wr_rdy        = (count != CNT_FULL);
  assign accept        = wr_vld && wr_rdy;
  assign push          = accept && dst_ok;
  assign pop           = popin && (count != '0);
  assign pndng_i_in    = (count != '0);
  assign data_out_i_in = pndng_i_in ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= packet;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bad_dst  <= 1'b0;
      drop_cnt <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      // Push+pop together holds occupancy.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      bad_dst <= accept && !dst_ok;
      if (accept && !dst_ok && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mesh_term_src.sv
`default_nettype none
// ============================================================================
// tb_mesh_term_src : vector table, directed sequences and random traffic
// against a queue-based reference model.  Rev 1.0
// ============================================================================
module tb_mesh_term_src;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int PW    = 40;
  localparam int DEPTH = 4;
  localparam int SR    = 0;
  localparam int SC    = 1;

  logic          clk;
  logic          reset;
  logic          wr_vld;
  logic          wr_rdy;
  logic [3:0]    wr_row;
  logic [3:0]    wr_colum;
  logic          wr_mode;
  logic [PW-18:0] wr_payload;
  logic          pndng_i_in;
  logic [PW-1:0] data_out_i_in;
  logic          popin;
  logic [2:0]    count;
  logic          bad_dst;
  logic [15:0]   drop_cnt;

  int checks;
  int errors;

  logic [PW-1:0] mq[$];
  int            m_drop;
  bit            m_bad;

  mesh_term_src #(
    .ROWS(ROWS), .COLUMS(COLS), .pckg_sz(PW), .fifo_depth(DEPTH),
    .SRC_ROW(SR), .SRC_COL(SC)
  ) dut (
    .clk(clk), .reset(reset), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .wr_row(wr_row), .wr_colum(wr_colum), .wr_mode(wr_mode),
    .wr_payload(wr_payload), .pndng_i_in(pndng_i_in),
    .data_out_i_in(data_out_i_in), .popin(popin), .count(count),
    .bad_dst(bad_dst), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit dst_valid(input int r, input int c);
    bit ns;
    bit ew;
    ns = (r == 0 || r == ROWS + 1) && c >= 1 && c <= COLS;
    ew = (c == 0 || c == COLS + 1) && r >= 1 && r <= ROWS;
    return (ns || ew) && !(r == SR && c == SC);
  endfunction

  function automatic logic [PW-1:0] pkt(input logic [3:0] r, input logic [3:0] c,
                                        input logic m, input logic [PW-18:0] p);
    return {8'h00, r, c, m, p};
  endfunction

  task automatic compare_model();
    logic [PW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    check("count", 64'(count), 64'(mq.size()));
    check("pndng", 64'(pndng_i_in), 64'(mq.size() != 0));
    check("data", 64'(data_out_i_in), 64'(head));
    check("wr_rdy", 64'(wr_rdy), 64'(mq.size() != DEPTH));
    check("bad_dst", 64'(bad_dst), 64'(m_bad));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  // Drive one cycle, advance the model from the pre-edge state, check after the edge.
  task automatic cyc(input bit v, input logic [3:0] r, input logic [3:0] c, input bit m,
                     input logic [PW-18:0] p, input bit pp, input bit rs);
    bit rdy;
    bit acc;
    bit ok;
    bit do_pop;
    wr_vld = v; wr_row = r; wr_colum = c; wr_mode = m; wr_payload = p;
    popin = pp; reset = rs;
    if (rs) begin
      mq.delete();
      m_drop = 0;
      m_bad  = 0;
    end else begin
      rdy    = (mq.size() != DEPTH);
      acc    = v && rdy;
      ok     = dst_valid(int'(r), int'(c));
      do_pop = pp && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (acc && ok) mq.push_back(pkt(r, c, m, p));
      m_bad = acc && !ok;
      if (acc && !ok && m_drop != 65535) m_drop++;
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    cyc(0, 4'd0, 4'd0, 0, '0, 0, 0);
  endtask

  task automatic do_pop_cycle();
    cyc(0, 4'd0, 4'd0, 0, '0, 1, 0);
  endtask

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    bit         exp_ok;
  } dst_vec_t;

  dst_vec_t vecs[14];

  initial begin
    checks = 0; errors = 0; m_drop = 0; m_bad = 0;
    wr_vld = 0; wr_row = 0; wr_colum = 0; wr_mode = 0; wr_payload = '0;
    popin = 0; reset = 1;

    vecs[0]  = '{4'd2, 4'd0, 1'b1};
    vecs[1]  = '{4'd1, 4'd1, 1'b0};
    vecs[2]  = '{4'd0, 4'd1, 1'b0};
    vecs[3]  = '{4'd0, 4'd2, 1'b1};
    vecs[4]  = '{4'd0, 4'd4, 1'b1};
    vecs[5]  = '{4'd0, 4'd5, 1'b0};
    vecs[6]  = '{4'd5, 4'd1, 1'b1};
    vecs[7]  = '{4'd5, 4'd0, 1'b0};
    vecs[8]  = '{4'd0, 4'd0, 1'b0};
    vecs[9]  = '{4'd4, 4'd5, 1'b1};
    vecs[10] = '{4'd1, 4'd0, 1'b1};
    vecs[11] = '{4'd6, 4'd2, 1'b0};
    vecs[12] = '{4'd3, 4'd15, 1'b0};
    vecs[13] = '{4'd5, 4'd4, 1'b1};

    // Reset held three cycles
    for (int i = 0; i < 3; i++) cyc(0, 4'd0, 4'd0, 0, '0, 0, 1);
    check("rst_pndng", 64'(pndng_i_in), 64'd0);
    check("rst_data", 64'(data_out_i_in), 64'd0);
    check("rst_wr_rdy", 64'(wr_rdy), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);

    // Destination table
    for (int i = 0; i < 14; i++) begin
      cyc(1, vecs[i].row, vecs[i].col, i[0], 23'(i + 16), 0, 0);
      check("tbl_bad", 64'(bad_dst), 64'(!vecs[i].exp_ok));
      check("tbl_count", 64'(count), 64'(vecs[i].exp_ok));
      if (vecs[i].exp_ok) begin
        check("tbl_data", 64'(data_out_i_in), 64'({8'h00, vecs[i].row, vecs[i].col, i[0], 23'(i + 16)}));
        do_pop_cycle();
      end
    end
    check("tbl_drops", 64'(drop_cnt), 64'd7);

    // Packet format example
    cyc(1, 4'd2, 4'd0, 1, 23'd1, 0, 0);
    check("fmt_pndng", 64'(pndng_i_in), 64'd1);
    check("fmt_data", 64'(data_out_i_in), 64'h0020800001);
    check("fmt_count", 64'(count), 64'd1);
    do_pop_cycle();

    // Fill, hold a request while full, pop to make room
    for (int k = 1; k <= 4; k++) cyc(1, 4'd2, 4'd0, 0, 23'(k), 0, 0);
    check("full_count", 64'(count), 64'd4);
    check("full_rdy", 64'(wr_rdy), 64'd0);
    cyc(1, 4'd2, 4'd0, 0, 23'd5, 0, 0);
    check("held_count", 64'(count), 64'd4);
    cyc(1, 4'd2, 4'd0, 0, 23'd5, 1, 0);
    check("pop_full_count", 64'(count), 64'd3);
    check("pop_full_rdy", 64'(wr_rdy), 64'd1);
    cyc(1, 4'd2, 4'd0, 0, 23'd5, 0, 0);
    check("fifth_count", 64'(count), 64'd4);
    for (int k = 2; k <= 5; k++) begin
      check("order", 64'(data_out_i_in[22:0]), 64'(k));
      do_pop_cycle();
    end
    check("drain_count", 64'(count), 64'd0);

    // Interior and self destinations dropped
    cyc(0, 4'd0, 4'd0, 0, '0, 0, 1);
    cyc(1, 4'd1, 4'd0, 0, 23'h11, 0, 0);
    cyc(1, 4'd1, 4'd1, 0, 23'h99, 0, 0);
    check("interior_bad", 64'(bad_dst), 64'd1);
    cyc(1, 4'd0, 4'd1, 0, 23'h98, 0, 0);
    check("self_bad", 64'(bad_dst), 64'd1);
    check("self_drop", 64'(drop_cnt), 64'd2);
    check("drop_count", 64'(count), 64'd1);
    idle();
    check("bad_pulse_end", 64'(bad_dst), 64'd0);

    // Push and pop together at count=2
    cyc(1, 4'd1, 4'd0, 0, 23'h22, 0, 0);
    cyc(1, 4'd1, 4'd0, 0, 23'h33, 1, 0);
    check("pp_count", 64'(count), 64'd2);
    check("pp_head", 64'(data_out_i_in[22:0]), 64'h22);
    do_pop_cycle();
    check("pp_tail", 64'(data_out_i_in[22:0]), 64'h33);
    do_pop_cycle();
    do_pop_cycle();
    check("empty_pop_count", 64'(count), 64'd0);
    check("empty_pop_data", 64'(data_out_i_in), 64'd0);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) cyc(1, 4'd0, 4'd3, 0, 23'(k), 0, 0);
    cyc(1, 4'd1, 4'd2, 0, 23'd0, 0, 0);
    cyc(1, 4'd0, 4'd3, 0, 23'd7, 1, 1);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_pndng", 64'(pndng_i_in), 64'd0);
    check("mid_rst_data", 64'(data_out_i_in), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 7,
          4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)),
          1'($urandom), 23'($urandom),
          $urandom_range(0, 9) < 4,
          $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
